// File: rtl/multiple_sequencer.sv
// Thumb PUSH/POP/LDMIA/STMIA sequencer: decodes the register list and issues
// one valid/ready memory beat per register, then a single base writeback.
module multiple_sequencer #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       instruction16,
  input  logic              is32,
  input  logic [ADDR_W-1:0] base_value,
  input  logic              mem_ready,
  output logic [9:0]        list,
  output logic              busy,
  output logic              xfer_valid,
  output logic              xfer_load,
  output logic [3:0]        xfer_reg,
  output logic [ADDR_W-1:0] xfer_addr,
  output logic              wb_valid,
  output logic [3:0]        wb_reg,
  output logic [ADDR_W-1:0] wb_value,
  output logic              done
);

  // Handshake: a beat transfers on any rising edge where xfer_valid and
  // mem_ready are both high; until then xfer_reg/xfer_addr/xfer_load hold.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;

  logic [9:0]        list_q;
  logic              load_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        wb_reg_q;
  logic [ADDR_W-1:0] wb_value_q;
  logic              wb_en_q;

  logic              dec_ok;
  logic              dec_load;
  logic              dec_down;
  logic              dec_ldm;
  logic [9:0]        dec_list;
  logic [3:0]        dec_n;
  logic [3:0]        dec_wb_reg;
  logic [2:0]        dec_rn;
  logic              dec_wb_en;
  logic [ADDR_W-1:0] dec_span;
  logic [ADDR_W-1:0] dec_first;
  logic [ADDR_W-1:0] dec_wb_value;

  logic              take;
  logic              accept;
  logic [9:0]        list_rest;
  logic [3:0]        cur_reg;

  always_comb begin
    dec_ok     = 1'b0;
    dec_load   = 1'b0;
    dec_down   = 1'b0;
    dec_ldm    = 1'b0;
    dec_list   = 10'd0;
    dec_wb_reg = 4'd0;
    dec_rn     = instruction16[10:8];
    dec_n      = 4'd0;
    if (instruction16[15:9] == 7'b1011010) begin
      dec_ok     = 1'b1;
      dec_down   = 1'b1;
      dec_list   = {1'b0, instruction16[8], instruction16[7:0]};
      dec_wb_reg = 4'd13;
    end else if (instruction16[15:9] == 7'b1011110) begin
      dec_ok     = 1'b1;
      dec_load   = 1'b1;
      dec_list   = {instruction16[8], 1'b0, instruction16[7:0]};
      dec_wb_reg = 4'd13;
    end else if (instruction16[15:12] == 4'b1100) begin
      dec_ok     = 1'b1;
      dec_load   = instruction16[11];
      dec_ldm    = instruction16[11];
      dec_list   = {2'b00, instruction16[7:0]};
      dec_wb_reg = {1'b0, dec_rn};
    end
    for (int i = 0; i < 10; i++) begin
      dec_n = dec_n + {3'b000, dec_list[i]};
    end
    // LDMIA whose base is also loaded keeps the loaded value, not the writeback.
    dec_wb_en    = dec_ok && (dec_n != 4'd0) && !(dec_ldm && instruction16[dec_rn]);
    dec_span     = {{(ADDR_W-6){1'b0}}, dec_n, 2'b00};
    dec_first    = dec_down ? (base_value - dec_span) : base_value;
    dec_wb_value = dec_down ? (base_value - dec_span) : (base_value + dec_span);
  end

  assign take      = (state == IDLE) && start && !is32 && dec_ok;
  assign accept    = (state == XFER) && mem_ready;
  assign list_rest = list_q & (list_q - 10'd1);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (take) state_nx = (dec_n == 4'd0) ? DONE : XFER;
      XFER: if (accept && (list_rest == 10'd0)) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      list_q     <= 10'd0;
      load_q     <= 1'b0;
      addr_q     <= '0;
      wb_reg_q   <= 4'd0;
      wb_value_q <= '0;
      wb_en_q    <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        list_q     <= dec_list;
        load_q     <= dec_load;
        addr_q     <= dec_first;
        wb_reg_q   <= dec_wb_reg;
        wb_value_q <= dec_wb_value;
        wb_en_q    <= dec_wb_en;
      end else if (accept) begin
        list_q <= list_rest;
        addr_q <= addr_q + ADDR_W'(4);
      end
    end
  end

  // Lowest set bit wins; bits 8/9 name LR and PC.
  always_comb begin
    cur_reg = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (list_q[i]) begin
        if (i == 9)      cur_reg = 4'd15;
        else if (i == 8) cur_reg = 4'd14;
        else             cur_reg = 4'(i);
      end
    end
  end

  assign list       = list_q;
  assign busy       = (state != IDLE);
  assign xfer_valid = (state == XFER);
  assign xfer_load  = load_q;
  assign xfer_reg   = cur_reg;
  assign xfer_addr  = addr_q;
  assign done       = (state == DONE);
  assign wb_valid   = (state == DONE) && wb_en_q;
  assign wb_reg     = wb_reg_q;
  assign wb_value   = wb_value_q;

endmodule

// File: tb/tb_multiple_sequencer.sv
// Bench for multiple_sequencer: directed and random PUSH/POP/LDMIA/STMIA
// sequences checked cycle by cycle against a list-of-registers model.
module tb_multiple_sequencer;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   instruction16;
  logic          is32;
  logic [AW-1:0] base_value;
  logic          mem_ready;
  logic [9:0]    list;
  logic          busy;
  logic          xfer_valid;
  logic          xfer_load;
  logic [3:0]    xfer_reg;
  logic [AW-1:0] xfer_addr;
  logic          wb_valid;
  logic [3:0]    wb_reg;
  logic [AW-1:0] wb_value;
  logic          done;

  int checks = 0;
  int errors = 0;

  multiple_sequencer #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .instruction16(instruction16),
    .is32(is32), .base_value(base_value), .mem_ready(mem_ready),
    .list(list), .busy(busy), .xfer_valid(xfer_valid), .xfer_load(xfer_load),
    .xfer_reg(xfer_reg), .xfer_addr(xfer_addr), .wb_valid(wb_valid),
    .wb_reg(wb_reg), .wb_value(wb_value), .done(done)
  );

  always #5 clk = ~clk;

  logic [86:0] all_out;
  assign all_out = {list, busy, xfer_valid, xfer_load, xfer_reg, xfer_addr,
                    wb_valid, wb_reg, wb_value, done};

  // Runs one sequence from an IDLE negedge and returns at the negedge of the
  // first IDLE cycle afterwards. mode: 0 ready=1, 1 random stalls, 2 three stalls first.
  task automatic run_seq(input string name, input logic [15:0] ins, input logic [AW-1:0] b,
                         input int mode, input bit poke);
    bit            ld;
    bit            wbv;
    logic [9:0]    lst;
    logic [3:0]    wr;
    logic [AW-1:0] first;
    logic [AW-1:0] wv;
    int            pos[$];
    int            n;
    int            idx;
    int            stalls;
    int            cyc;
    logic [AW-1:0] addr;
    logic [9:0]    rem;
    logic [3:0]    r;
    logic [47:0]   exp_beat;
    logic [47:0]   got_beat;
    ld = 0; wbv = 0; lst = '0; wr = '0;
    if (ins[15:9] == 7'b1011010) begin
      lst = {1'b0, ins[8], ins[7:0]}; wr = 4'd13;
    end else if (ins[15:9] == 7'b1011110) begin
      lst = {ins[8], 1'b0, ins[7:0]}; ld = 1; wr = 4'd13;
    end else begin
      lst = {2'b00, ins[7:0]}; ld = ins[11]; wr = {1'b0, ins[10:8]};
    end
    for (int i = 0; i < 10; i++) if (lst[i]) pos.push_back(i);
    n = pos.size();
    if (ins[15:9] == 7'b1011010) begin
      first = b - AW'(4 * n); wv = first;
    end else begin
      first = b; wv = b + AW'(4 * n);
    end
    wbv = (n != 0) && !(ins[15:11] == 5'b11001 && ins[ins[10:8]]);

    is32 = 1'b0; start = 1'b1; instruction16 = ins; base_value = b; mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 0; stalls = 0; cyc = 0; addr = first;
    while (idx < n && cyc < 200) begin
      rem = '0;
      for (int j = idx; j < n; j++) rem[pos[j]] = 1'b1;
      r = (pos[idx] < 8) ? 4'(pos[idx]) : ((pos[idx] == 8) ? 4'd14 : 4'd15);
      exp_beat = {1'b1, 1'b1, ld, r, addr, rem, 1'b0, 1'b0};
      got_beat = {busy, xfer_valid, xfer_load, xfer_reg, xfer_addr, list, done, wb_valid};
      checks++;
      if (got_beat !== exp_beat) begin
        errors++;
        $display("FAIL %s beat%0d cyc%0d: got %h expected %h", name, idx, cyc, got_beat, exp_beat);
      end
      case (mode)
        0: mem_ready = 1'b1;
        1: mem_ready = ($urandom_range(0, 3) != 0) || (stalls >= 8);
        default: mem_ready = (cyc >= 3);
      endcase
      if (!mem_ready) stalls++;
      if (poke) begin
        start = 1'b1; instruction16 = 16'hB5FF; base_value = $urandom;
      end
      @(negedge clk);
      cyc++;
      if (mem_ready) begin
        idx++; addr = addr + AW'(4);
      end
    end
    if (cyc >= 200) begin
      errors++;
      $display("FAIL %s cycle budget expired", name);
    end
    checks++;
    if ({busy, xfer_valid, list, done, wb_valid} !== {1'b1, 1'b0, 10'd0, 1'b1, wbv}) begin
      errors++;
      $display("FAIL %s done_cycle: got %b expected %b", name,
               {busy, xfer_valid, list, done, wb_valid}, {1'b1, 1'b0, 10'd0, 1'b1, wbv});
    end
    if (wbv) begin
      checks++;
      if ({wb_reg, wb_value} !== {wr, wv}) begin
        errors++;
        $display("FAIL %s writeback: got r%0d=%h expected r%0d=%h", name, wb_reg, wb_value, wr, wv);
      end
    end
    mem_ready = 1'b1;
    if (poke) begin
      start = 1'b1; instruction16 = 16'hBCFF;
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, xfer_valid, list, done, wb_valid} !== 14'd0) begin
      errors++;
      $display("FAIL %s idle_after: got %b expected 0", name, {busy, xfer_valid, list, done, wb_valid});
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (all_out !== 87'd0) begin
      errors++;
      $display("FAIL reset_held: got %h expected 0", all_out);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (all_out !== 87'd0) begin
      errors++;
      $display("FAIL reset_released: got %h expected 0", all_out);
    end
  endtask

  task automatic test_push; run_seq("push_r4_r7_lr", 16'hB590, 32'h2000_0100, 0, 0); endtask
  task automatic test_pop;  run_seq("pop_r0_pc", 16'hBD01, 32'h2000_00F4, 0, 0); endtask
  task automatic test_ldm_suppress; run_seq("ldmia_r2_in_list", 16'hCA06, 32'h0000_0100, 0, 0); endtask
  task automatic test_stm_stall; run_seq("stmia_stall", 16'hC301, 32'h0000_0300, 2, 0); endtask
  task automatic test_empty_push; run_seq("push_empty", 16'hB400, 32'h0000_1000, 0, 0); endtask
  task automatic test_busy_start; run_seq("busy_start", 16'hBC0F, 32'h0000_2000, 1, 1); endtask

  task automatic test_ignored_starts;
    logic [15:0] ign[2];
    logic        ign32[2];
    ign[0] = 16'hB590; ign32[0] = 1'b1;
    ign[1] = 16'h4000; ign32[1] = 1'b0;
    for (int t = 0; t < 2; t++) begin
      start = 1'b1; is32 = ign32[t]; instruction16 = ign[t]; base_value = 32'h0000_4000;
      @(negedge clk);
      start = 1'b0; is32 = 1'b0;
      for (int c = 0; c < 2; c++) begin
        checks++;
        if ({busy, xfer_valid, list, done, wb_valid} !== 14'd0) begin
          errors++;
          $display("FAIL ignored_start%0d c%0d: got %b expected 0", t, c,
                   {busy, xfer_valid, list, done, wb_valid});
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_back_to_back;
    run_seq("b2b_stm", 16'hC083, 32'h0000_0500, 0, 0);
    run_seq("b2b_ldm", 16'hC988, 32'h0000_0600, 1, 0);
    run_seq("b2b_push_wrap", 16'hB503, 32'h0000_0004, 0, 0);
  endtask

  task automatic test_random;
    logic [15:0]   ins;
    logic [7:0]    rl;
    logic [AW-1:0] b;
    for (int i = 0; i < 24; i++) begin
      rl = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      b  = (i % 6 == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      case ($urandom_range(0, 3))
        0: ins = {7'b1011010, 1'($urandom_range(0, 1)), rl};
        1: ins = {7'b1011110, 1'($urandom_range(0, 1)), rl};
        2: ins = {5'b11000, 3'($urandom_range(0, 7)), rl};
        default: ins = {5'b11001, 3'($urandom_range(0, 7)), rl};
      endcase
      run_seq($sformatf("rand%0d_%h", i, ins), ins, b, 1, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid;
    start = 1'b1; instruction16 = 16'hC00F; base_value = 32'h0000_0400; mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({xfer_valid, xfer_reg} !== {1'b1, 4'd2}) begin
      errors++;
      $display("FAIL reset_mid_setup: got %b expected %b", {xfer_valid, xfer_reg}, {1'b1, 4'd2});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (all_out !== 87'd0) begin
      errors++;
      $display("FAIL reset_mid: got %h expected 0", all_out);
    end
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({wb_valid, busy, done} !== 3'b000) begin
        errors++;
        $display("FAIL reset_mid_after c%0d: got %b expected 000", c, {wb_valid, busy, done});
      end
    end
    run_seq("after_reset_stm", 16'hC00F, 32'h0000_0400, 0, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; is32 = 1'b0; instruction16 = '0;
    base_value = '0; mem_ready = 1'b1;
    test_reset();
    test_push();
    test_pop();
    test_ldm_suppress();
    test_stm_stall();
    test_empty_push();
    test_ignored_starts();
    test_busy_start();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiple_sequencer.md
# multiple_sequencer

Executes the Thumb load/store-multiple group (PUSH, POP, LDMIA, STMIA) one register per beat. It sits downstream of the fetch stage and consumes that stage's `multiple_pulse` and `instruction16`. It returns the 10-bit remaining-register `list`, which fetch uses to hold the pipeline until the transfer sequence drains. Memory beats use a valid/ready handshake, and base-register writeback is issued once at the end.

## Interface
Parameters:
- ADDR_W, 32, width of base value, beat address and writeback value

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  `multiple_pulse` from fetch; request to begin a sequence
- instruction16  in  16  current 16-bit instruction from fetch
- is32  in  1  current instruction is 32-bit; start is ignored when high
- base_value  in  ADDR_W  register-file value of SP (PUSH/POP) or Rn (LDM/STM), sampled with start
- mem_ready  in  1  memory accepts the current beat
- list  out  10  remaining registers: [7:0] r0–r7, [8] LR, [9] PC
- busy  out  1  sequence in progress; fetch stalls while high
- xfer_valid  out  1  beat presented
- xfer_load  out  1  1 = load (POP/LDM), 0 = store (PUSH/STM)
- xfer_reg  out  4  register number of the current beat (LR = 14, PC = 15)
- xfer_addr  out  ADDR_W  word address of the current beat
- wb_valid  out  1  base writeback strobe, one cycle
- wb_reg  out  4  register written back (13 for PUSH/POP)
- wb_value  out  ADDR_W  new base value
- done  out  1  one-cycle end-of-sequence pulse

## Operation
- Decode when start=1, is32=0 and state IDLE. All other starts are ignored.
- PUSH `1011010M rlist`: list = {0, M, rlist}; store; first address = base − 4N; wb_value = SP − 4N.
- POP `1011110P rlist`: list = {P, 0, rlist}; load; first address = base; wb_value = SP + 4N.
- STMIA `11000 Rn rlist`: list = {00, rlist}; store; first address = base; wb to Rn = base + 4N.
- LDMIA `11001 Rn rlist`: as STMIA but load. Writeback is suppressed if Rn is in rlist.
- Unrecognised encoding with start=1: ignored, state stays IDLE.
- N = popcount(list), computed at decode with 4-bit result (max 10).
- Beats are issued lowest set bit first. Address advances +4 per accepted beat. Wrap-around is modulo 2^ADDR_W.
- States:
  - IDLE → XFER on valid start with N > 0.
  - IDLE → DONE on valid start with N = 0 (empty list: no beats, no writeback).
  - XFER → XFER on accept while bits remain.
  - XFER → DONE on accept of the last bit.
  - DONE → IDLE unconditionally.
- Accept = xfer_valid & mem_ready at a clock edge. On accept, clear the lowest set bit of list and step xfer_addr. Without accept, all beat outputs hold.
- In DONE: done=1. wb_valid=1 unless suppressed or the list was empty.
- list is 0 in IDLE and DONE. In XFER it includes the beat currently presented.

## Timing
- Reset (rst=0 at edge): state IDLE; list, busy, xfer_valid, xfer_load, xfer_reg, xfer_addr, wb_valid, wb_reg, wb_value, done all 0. Applies mid-sequence too; the in-flight beat is dropped with no writeback.
- Valid start at edge k:
  - First beat is presented in cycle k+1.
  - busy=1 from cycle k+1 through the DONE cycle inclusive.
- With mem_ready held at 1: beats occupy cycles k+1 … k+N, DONE is cycle k+N+1, and IDLE resumes at k+N+2.
- A start during busy is ignored, including during the DONE cycle.
- The earliest new start is sampled at the edge ending the first IDLE cycle.
- mem_ready low stretches the sequence one cycle per stall. xfer_reg and xfer_addr stay stable while not accepted.
- wb_valid and done are coincident, each exactly one cycle.

## Test plan
- Reset: hold rst=0 for 2 edges mid-sequence (after beat 2 of a 4-beat STM) → all outputs 0 the next cycle; no wb_valid ever asserted.
- PUSH {r4,r7,LR} (0xB590), SP=0x2000_0100, mem_ready=1:
  - list 0x190 → 0x180 → 0x100 in consecutive beat cycles.
  - Stores to r4@0x2000_00F4, r7@0x2000_00F8, r14@0x2000_00FC.
  - Then wb r13=0x2000_00F4 with done.
- POP {r0,PC} (0xBD01), SP=0x2000_00F4 → loads r0@0x2000_00F4 and r15@0x2000_00F8, then wb r13=0x2000_00FC.
- LDMIA r2!,{r1,r2} (0xCA06), base 0x100 → loads r1@0x100 and r2@0x104. Done pulses with wb_valid=0.
- STMIA r3!,{r0} with mem_ready low for 3 cycles:
  - xfer_addr holds at base for 4 cycles.
  - Done follows on the cycle after the accept.
  - wb r3=base+4.
- Corner cases:
  - Empty-list PUSH (0xB400): done pulses on cycle k+1, no beats, no wb.
  - start with is32=1: no response.
  - Second start during busy: ignored.
